// File: rtl/insn_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : insn_decode_stage
//  Purpose  : Registered instruction-decode stage. Classifies raw words by
//             flag field, extracts fields, buffers up to two decoded records
//             (output + skid register), sequences halt, supports flush and
//             keeps a saturating illegal-instruction count.
//  Revision : 1.0  initial release
// ============================================================================
module insn_decode_stage #(
    parameter int INSN_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int FUNC_WIDTH = 5,
    parameter int NUM_FUNCS  = 17,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSN_WIDTH-1:0] in_insn,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [2:0]            out_kind,
    output logic [REG_WIDTH-1:0]  out_reg_a,
    output logic [REG_WIDTH-1:0]  out_reg_b,
    output logic [FUNC_WIDTH-1:0] out_func,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic                  out_relative,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  illegal_count
);

    generate
        if (INSN_WIDTH != 3 + 2*REG_WIDTH + FUNC_WIDTH) begin : g_bad_insn_width
            $error("INSN_WIDTH must equal 3 + 2*REG_WIDTH + FUNC_WIDTH");
        end
        if (DATA_WIDTH < INSN_WIDTH) begin : g_bad_data_width
            $error("DATA_WIDTH must be >= INSN_WIDTH");
        end
    endgenerate

    localparam int c_TOP       = INSN_WIDTH - 1;
    localparam int c_SET_IMM_W = INSN_WIDTH - 1 - REG_WIDTH;
    localparam int c_BR_IMM_W  = INSN_WIDTH - 4;
    localparam logic [FUNC_WIDTH:0] c_NUM_FUNCS = (FUNC_WIDTH+1)'(NUM_FUNCS);

    localparam logic [2:0] c_K_NOP     = 3'd0;
    localparam logic [2:0] c_K_SET     = 3'd1;
    localparam logic [2:0] c_K_BRANCH  = 3'd2;
    localparam logic [2:0] c_K_JUMP    = 3'd3;
    localparam logic [2:0] c_K_OP      = 3'd4;
    localparam logic [2:0] c_K_HALT    = 3'd5;
    localparam logic [2:0] c_K_ILLEGAL = 3'd6;

    localparam logic [1:0] c_S_RUN    = 2'd0;
    localparam logic [1:0] c_S_DRAIN  = 2'd1;
    localparam logic [1:0] c_S_HALTED = 2'd2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [2:0]            kind;
        logic [REG_WIDTH-1:0]  ra;
        logic [REG_WIDTH-1:0]  rb;
        logic [FUNC_WIDTH-1:0] func;
        logic [DATA_WIDTH-1:0] imm;
        logic                  rel;
    } rec_t;

    rec_t                 r_out;
    rec_t                 r_skid;
    logic                 r_out_valid;
    logic                 r_skid_valid;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_illegal_count;

    rec_t                 w_dec;
    logic                 w_accept;
    logic                 w_drain;
    logic [DATA_WIDTH-1:0] w_br_imm_sx;
    logic [DATA_WIDTH-1:0] w_br_imm_zx;

    // in_ready comes only from registered state so it never depends on out_ready/flush.
    assign in_ready = !r_skid_valid && (r_state == c_S_RUN);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_drain  = r_out_valid && out_ready;

    assign w_br_imm_sx = {{(DATA_WIDTH-c_BR_IMM_W){in_insn[c_BR_IMM_W-1]}}, in_insn[c_BR_IMM_W-1:0]};
    assign w_br_imm_zx = DATA_WIDTH'(in_insn[c_BR_IMM_W-1:0]);

    // Combinational decode of the presented word; unused fields stay zero.
    always_comb begin
        w_dec    = '0;
        w_dec.pc = in_pc;
        if (in_insn[c_TOP]) begin
            w_dec.kind = c_K_SET;
            w_dec.ra   = in_insn[c_TOP-1 -: REG_WIDTH];
            w_dec.imm  = DATA_WIDTH'(in_insn[c_SET_IMM_W-1:0]);
        end else if (in_insn[c_TOP-1]) begin
            w_dec.kind = in_insn[c_TOP-2] ? c_K_BRANCH : c_K_JUMP;
            w_dec.rel  = in_insn[c_TOP-3];
            w_dec.imm  = in_insn[c_TOP-3] ? w_br_imm_sx : w_br_imm_zx;
        end else if (in_insn[c_TOP-2]) begin
            if ({1'b0, in_insn[FUNC_WIDTH-1:0]} >= c_NUM_FUNCS) begin
                w_dec.kind = c_K_ILLEGAL;
            end else begin
                w_dec.kind = c_K_OP;
                w_dec.ra   = in_insn[c_TOP-3 -: REG_WIDTH];
                w_dec.rb   = in_insn[c_TOP-3-REG_WIDTH -: REG_WIDTH];
                w_dec.func = in_insn[FUNC_WIDTH-1:0];
            end
        end else if (in_insn == '0) begin
            w_dec.kind = c_K_HALT;
        end else if (in_insn == INSN_WIDTH'(1)) begin
            w_dec.kind = c_K_NOP;
        end else begin
            w_dec.kind = c_K_ILLEGAL;
        end
    end

    // Two-entry buffer: output register fed directly or from the skid entry, order preserved.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush && (r_state != c_S_HALTED)) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_dec;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end else begin
                r_out        <= w_dec;
                r_out_valid  <= 1'b1;
            end
        end
    end

    // Halt sequencing: stop accepting after HALT, go terminal once HALT leaves the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_RUN;
        end else begin
            case (r_state)
                c_S_RUN: begin
                    if (w_accept && (w_dec.kind == c_K_HALT)) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    if (flush) begin
                        r_state <= c_S_RUN;
                    end else if (w_drain && (r_out.kind == c_K_HALT)) begin
                        r_state <= c_S_HALTED;
                    end
                end
                c_S_HALTED: r_state <= c_S_HALTED;
                default:    r_state <= c_S_RUN;
            endcase
        end
    end

    // Saturating count of accepted illegal words, counted at acceptance even if later flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_count <= '0;
        end else if (w_accept && (w_dec.kind == c_K_ILLEGAL) && (r_illegal_count != '1)) begin
            r_illegal_count <= r_illegal_count + 1'b1;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_pc        = r_out.pc;
    assign out_kind      = r_out.kind;
    assign out_reg_a     = r_out.ra;
    assign out_reg_b     = r_out.rb;
    assign out_func      = r_out.func;
    assign out_imm       = r_out.imm;
    assign out_relative  = r_out.rel;
    assign halted        = (r_state == c_S_HALTED);
    assign illegal_count = r_illegal_count;

endmodule
`default_nettype wire
